// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package mips_pkg;

   // Loader FSM states.
   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      DATA,
      WRITE,
      DONE,
      ERROR
   } load_state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int INSTR_WIDTH    = 32;

endpackage

// File: rtl/imem_stream_loader_packer.sv
// Big-endian byte-to-word packer: the first accepted byte ends up in bits
// [31:24] once four bytes have been shifted in.
module imem_byte_packer
   import mips_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   byte_valid_i,
   input  logic [7:0]             byte_i,
   input  logic                   clear_i,
   output logic [INSTR_WIDTH-1:0] word_o,
   output logic                   word_full_o
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [INSTR_WIDTH-1:0] word_q, word_d;
   logic [1:0]             idx_q, idx_d;

   // Shift in accepted bytes; the word-written pulse discards the word.
   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (clear_i) begin
         word_d = '0;
         idx_d  = '0;
      end else if (byte_valid_i) begin
         word_d = {word_q[INSTR_WIDTH-9:0], byte_i};
         idx_d  = idx_q + 2'd1;
      end
   end

   // Packer registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

   assign word_o      = word_q;
   assign word_full_o = byte_valid_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: parses a 16-bit big-endian word count followed by that many
// big-endian instruction words, writes them to instruction memory and then
// releases the processor reset.
//
// Handshake: a byte moves on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state; the source must hold in_data
// stable while in_valid is high and in_ready is low.
module imem_stream_loader
   import mips_pkg::*;
#(
   parameter int IMEM_WORDS = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   imem_we,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   output logic [INSTR_WIDTH-1:0] imem_wdata,
   output logic                   cpu_reset,
   output logic                   load_done,
   output logic                   load_error
);

   // One extra bit so the index can reach the count IMEM_WORDS itself.
   localparam int          IDX_W     = ADDR_WIDTH + 1;
   localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

   load_state_t            state_q, state_d;
   logic [15:0]            count_q, count_d;
   logic [IDX_W-1:0]       widx_q, widx_d;
   logic [IDX_W-1:0]       widx_inc;
   logic [15:0]            hdr_n;
   logic                   xfer;
   logic                   pack_valid;
   logic                   word_full;
   logic [INSTR_WIDTH-1:0] packed_word;

   assign in_ready   = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
   assign xfer       = in_valid && in_ready;
   assign pack_valid = xfer && (state_q == DATA);
   assign hdr_n      = {count_q[15:8], in_data};
   assign widx_inc   = widx_q + IDX_W'(1);

   imem_byte_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .byte_valid_i (pack_valid),
      .byte_i       (in_data),
      .clear_i      (state_q == WRITE),
      .word_o       (packed_word),
      .word_full_o  (word_full)
   );

   // Next-state logic: header parse, data collection, one-cycle write.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      widx_d  = widx_q;
      case (state_q)
         HDR_HI: begin
            if (xfer) begin
               count_d = {in_data, 8'h00};
               state_d = HDR_LO;
            end
         end
         HDR_LO: begin
            if (xfer) begin
               count_d = hdr_n;
               widx_d  = '0;
               if (hdr_n == 16'd0) begin
                  state_d = DONE;
               end else if ({1'b0, hdr_n} > MAX_WORDS) begin
                  state_d = ERROR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (word_full) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            widx_d = widx_inc;
            if (17'(widx_inc) == {1'b0, count_q}) begin
               state_d = DONE;
            end else begin
               state_d = DATA;
            end
         end
         DONE:    state_d = DONE;
         ERROR:   state_d = ERROR;
         default: state_d = HDR_HI;
      endcase
   end

   // State, word count and word index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HDR_HI;
         count_q <= '0;
         widx_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         widx_q  <= widx_d;
      end
   end

   assign imem_we    = (state_q == WRITE);
   assign imem_addr  = widx_q[ADDR_WIDTH-1:0];
   assign imem_wdata = packed_word;
   assign cpu_reset  = (state_q != DONE);
   assign load_done  = (state_q == DONE);
   assign load_error = (state_q == ERROR);

endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: random-gap byte streams, expected writes
// derived from the stream format, scoreboard on the write port.
module tb_imem_stream_loader;

   localparam int IMEM_WORDS = 256;
   localparam int ADDR_WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic                  cpu_reset;
   logic                  load_done;
   logic                  load_error;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          writes_this_load = 0;
   int          last_we_cyc = -10;
   logic        prev_done = 1'b0;
   logic [39:0] exp_q[$];
   logic [31:0] wq[$];

   imem_stream_loader #(
      .IMEM_WORDS (IMEM_WORDS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .load_error (load_error)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // scoreboard / monitor on the write port
   always @(negedge clk) begin
      logic [39:0] e;
      if (!reset) begin
         if (imem_we) begin
            writes_this_load++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
               check_eq("we_expected", 64'(imem_we), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check_eq("write", 64'({imem_addr, imem_wdata}), 64'(e));
            end
         end
         if (!load_done && !load_error)
            check_eq("in_ready_vs_we", 64'(in_ready), 64'(!imem_we));
         if (load_done && !prev_done) begin
            check_eq("cpu_reset_at_done", 64'(cpu_reset), 64'(0));
            if (writes_this_load > 0)
               check_eq("done_latency", 64'(cyc), 64'(last_we_cyc + 1));
         end
         prev_done = load_done;
      end else begin
         prev_done = 1'b0;
      end
   end

   // driver tasks (called and returning on a falling edge)
   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(negedge clk);
      check_eq("rst_in_ready", 64'(in_ready), 64'(1));
      check_eq("rst_we", 64'(imem_we), 64'(0));
      check_eq("rst_addr", 64'(imem_addr), 64'(0));
      check_eq("rst_wdata", 64'(imem_wdata), 64'(0));
      check_eq("rst_cpu_reset", 64'(cpu_reset), 64'(1));
      check_eq("rst_done", 64'(load_done), 64'(0));
      check_eq("rst_error", 64'(load_error), 64'(0));
      exp_q.delete();
      reset = 1'b0;
      writes_this_load = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int   gap;
      int   waited;
      logic rdy;
      gap    = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      waited = 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      forever begin
         rdy = in_ready;
         @(negedge clk);
         if (rdy) break;
         waited++;
         if (waited > 20) begin
            check_eq("handshake_timeout", 64'(rdy), 64'(1));
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   // Reference: a count of 1..IMEM_WORDS yields one write per word at
   // consecutive addresses; 0 finishes at once; larger counts are an error.
   task automatic run_load(input int n, input int gap_max);
      int exp_writes;
      int w;
      exp_writes = (n > 0 && n <= IMEM_WORDS) ? n : 0;
      writes_this_load = 0;
      for (int i = 0; i < exp_writes; i++) exp_q.push_back({8'(i), wq[i]});
      send_byte(8'(n >> 8), gap_max);
      send_byte(8'(n), gap_max);
      if (n == 0) check_eq("empty_done_now", 64'(load_done), 64'(1));
      if (n > IMEM_WORDS) check_eq("oversize_error_now", 64'(load_error), 64'(1));
      for (int i = 0; i < exp_writes; i++)
         for (int b = 0; b < 4; b++)
            send_byte(wq[i][31-8*b -: 8], gap_max);
      w = 0;
      while (!load_done && !load_error && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (n > IMEM_WORDS) begin
         check_eq("err_flag", 64'(load_error), 64'(1));
         check_eq("err_done", 64'(load_done), 64'(0));
         check_eq("err_cpu_reset", 64'(cpu_reset), 64'(1));
      end else begin
         check_eq("done_flag", 64'(load_done), 64'(1));
         check_eq("done_error", 64'(load_error), 64'(0));
         check_eq("done_cpu_reset", 64'(cpu_reset), 64'(0));
      end
      check_eq("final_in_ready", 64'(in_ready), 64'(0));
      check_eq("write_count", 64'(writes_this_load), 64'(exp_writes));
      check_eq("exp_q_drained", 64'(exp_q.size()), 64'(0));
      // Bytes offered after the load finishes must be refused.
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      repeat (3) begin
         @(negedge clk);
         check_eq("post_in_ready", 64'(in_ready), 64'(0));
      end
      in_valid = 1'b0;
      check_eq("post_write_count", 64'(writes_this_load), 64'(exp_writes));
   endtask

   initial begin
      int n;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;

      // Basic load, no gaps, then the same stream with random stalls.
      do_reset();
      wq = '{32'h010A4820, 32'h01286022};
      run_load(2, 0);
      do_reset();
      run_load(2, 3);

      // Empty program.
      do_reset();
      run_load(0, 2);

      // Oversize header, then recovery with a single word.
      do_reset();
      run_load(257, 0);
      do_reset();
      wq = '{32'($urandom)};
      run_load(1, 2);

      // Full memory, word i = i.
      do_reset();
      wq.delete();
      for (int i = 0; i < IMEM_WORDS; i++) wq.push_back(32'(i));
      run_load(IMEM_WORDS, 0);

      // Reset after the first word and one byte of the second.
      do_reset();
      wq = '{32'hCAFE0001, 32'hBEEF0002};
      writes_this_load = 0;
      exp_q.push_back({8'd0, wq[0]});
      send_byte(8'h00, 1);
      send_byte(8'h02, 1);
      for (int b = 0; b < 4; b++) send_byte(wq[0][31-8*b -: 8], 1);
      send_byte(wq[1][31:24], 1);
      repeat (2) @(negedge clk);
      check_eq("midload_writes", 64'(writes_this_load), 64'(1));
      check_eq("midload_cpu_reset", 64'(cpu_reset), 64'(1));
      do_reset();
      wq = '{32'h8D0A0000};
      run_load(1, 1);

      // Random programs with random stalls.
      repeat (4) begin
         n = int'($urandom_range(12, 1));
         wq.delete();
         for (int i = 0; i < n; i++) wq.push_back(32'($urandom));
         do_reset();
         run_load(n, 3);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
